// File: rtl/de1_soc_qsys_nios2_qsys_div_cell.sv
`default_nettype none
// ============================================================================
// Module   : de1_soc_qsys_nios2_qsys_div_cell
// Purpose  : Sequential radix-2 restoring integer divider for the Nios II
//            A-stage. Takes a dividend/divisor pair on a start pulse and
//            returns quotient and remainder after a fixed 34-cycle latency.
//            Signed operation divides the operand magnitudes and fixes the
//            result signs afterwards (truncation toward zero, remainder
//            carries the dividend's sign).
// Ports    : clk             - clock, rising edge
//            reset           - synchronous active-high reset
//            A_div_start     - request, honoured only when idle
//            A_div_signed    - 1 = two's-complement operands
//            A_div_src1      - dividend
//            A_div_src2      - divisor
//            A_div_busy      - operation in progress, start ignored
//            A_div_done      - one-cycle pulse, results valid
//            A_div_quotient  - quotient
//            A_div_remainder - remainder
//            A_div_by_zero   - divisor was zero for the current result
// Revision : 1.0 - initial release
// ============================================================================
module de1_soc_qsys_nios2_qsys_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             A_div_start,
  input  logic             A_div_signed,
  input  logic [WIDTH-1:0] A_div_src1,
  input  logic [WIDTH-1:0] A_div_src2,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_quotient,
  output logic [WIDTH-1:0] A_div_remainder,
  output logic             A_div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;       // partial remainder
  logic [WIDTH-1:0] dvd_q;       // dividend magnitude, becomes quotient
  logic [WIDTH-1:0] dsr_q;       // divisor magnitude
  logic [WIDTH-1:0] orig_q;      // original dividend for divide-by-zero
  logic             q_neg_q;     // quotient must be negated
  logic             r_neg_q;     // remainder must be negated
  logic             zero_q;      // divisor was zero

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remo_q;
  logic             byz_q;

  // Operand magnitudes for the start cycle
  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;

  // One restoring iteration
  logic [WIDTH:0]   rem_sh;      // {remainder, dividend MSB}
  logic [WIDTH:0]   trial;       // rem_sh - divisor, MSB is the borrow
  logic             borrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;

  // Final sign-corrected results
  logic [WIDTH-1:0] quot_d;
  logic [WIDTH-1:0] remo_d;

  always_comb begin
    src1_neg = A_div_signed & A_div_src1[WIDTH-1];
    src2_neg = A_div_signed & A_div_src2[WIDTH-1];
    src1_mag = src1_neg ? (~A_div_src1 + 1'b1) : A_div_src1;
    src2_mag = src2_neg ? (~A_div_src2 + 1'b1) : A_div_src2;
  end

  // The partial remainder stays below the divisor, so the shifted value is
  // below twice the divisor and a 33-bit difference suffices: its MSB is set
  // exactly when the subtraction borrows. A zero divisor breaks that bound,
  // but its result is replaced wholesale in FIX.
  always_comb begin
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dsr_q};
    borrow = trial[WIDTH];
    rem_d  = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_d  = {dvd_q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
    if (zero_q) begin
      quot_d = '1;
      remo_d = orig_q;
    end else begin
      quot_d = q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
      remo_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      orig_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      byz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (A_div_start) begin
            state_q <= S_CALC;
            busy_q  <= 1'b1;
            cnt_q   <= C_CNT_LOAD;
            rem_q   <= '0;
            dvd_q   <= src1_mag;
            dsr_q   <= src2_mag;
            orig_q  <= A_div_src1;
            q_neg_q <= src1_neg ^ src2_neg;
            r_neg_q <= src1_neg;
            zero_q  <= (A_div_src2 == '0);
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          quot_q  <= quot_d;
          remo_q  <= remo_d;
          byz_q   <= zero_q;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign A_div_busy      = busy_q;
  assign A_div_done      = done_q;
  assign A_div_quotient  = quot_q;
  assign A_div_remainder = remo_q;
  assign A_div_by_zero   = byz_q;

endmodule
`default_nettype wire

// File: tb/tb_de1_soc_qsys_nios2_qsys_div_cell.sv
`default_nettype none
// ============================================================================
// Module   : tb_de1_soc_qsys_nios2_qsys_div_cell
// Purpose  : Self-checking bench for the divider cell: directed vector table,
//            control-sequencing scenario and randomized operations against
//            an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_de1_soc_qsys_nios2_qsys_div_cell;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sgn;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        byz;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  de1_soc_qsys_nios2_qsys_div_cell #(.WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .A_div_start     (start),
    .A_div_signed    (sgn),
    .A_div_src1      (src1),
    .A_div_src2      (src2),
    .A_div_busy      (busy),
    .A_div_done      (done),
    .A_div_quotient  (quot),
    .A_div_remainder (rem),
    .A_div_by_zero   (byz)
  );

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          z;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer division on 64-bit values
  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output bit z);
    longint x;
    longint y;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      if (s) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'd0, a});
        y = longint'({32'd0, b});
      end
      q = 32'(x / y);
      r = 32'(x % y);
      z = 1'b0;
    end
  endfunction

  // Issue one operation, check busy profile, done latency and results.
  task automatic run_op(input string name, input bit s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input bit ez);
    int n;
    int busy_err;
    start = 1'b1; sgn = s; src1 = a; src2 = b;
    tick();
    start = 1'b0;
    // operands may change freely once accepted
    src1 = $urandom; src2 = $urandom; sgn = 1'($urandom);
    n = 1;
    busy_err = 0;
    while (!done && n < 40) begin
      if (busy !== 1'b1) busy_err++;
      tick();
      n++;
    end
    check({name, " busy"}, 32'(busy_err), 32'd0);
    check({name, " latency"}, 32'(n), 32'd34);
    check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({name, " quot"}, quot, eq);
    check({name, " rem"}, rem, er);
    check({name, " byz"}, {31'd0, byz}, {31'd0, ez});
    tick();
    check({name, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] mq;
    logic [31:0] mr;
    bit          mz;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;
    int          hits;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    vecs[7] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};

    reset = 1'b1; start = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0;
    tick(); tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quot", quot, 32'd0);
    check("reset rem",  rem,  32'd0);
    check("reset byz",  {31'd0, byz}, 32'd0);
    reset = 1'b0;
    tick();

    // directed table
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
             vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // control sequencing; cyc counts cycles from the first start
    cyc = 0;
    start = 1'b1; sgn = 1'b0; src1 = 32'd100; src2 = 32'd7;
    tick();
    start = 1'b0;
    hits = 0;
    while (cyc < 34) begin
      if (cyc == 5) begin
        start = 1'b1; src1 = 32'd9; src2 = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) hits++;
      tick();
    end
    check("seq done_before_34", 32'(hits), 32'd0);
    check("seq done_34", {31'd0, done}, 32'd1);
    check("seq quot_34", quot, 32'd14);
    check("seq rem_34",  rem,  32'd2);
    start = 1'b1; sgn = 1'b0; src1 = 32'd9; src2 = 32'd3;
    tick();
    start = 1'b0;
    hits = 0;
    while (cyc < 68) begin
      if (done) hits++;
      tick();
    end
    check("seq done_35_67", 32'(hits), 32'd0);
    check("seq done_68", {31'd0, done}, 32'd1);
    check("seq quot_68", quot, 32'd3);
    check("seq rem_68",  rem,  32'd0);
    tick(); tick();
    start = 1'b1; sgn = 1'b1; src1 = 32'd12345; src2 = 32'd17;
    tick();
    start = 1'b0;
    while (cyc < 80) tick();
    reset = 1'b1;
    start = 1'b1;   // reset must win
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("seq rst busy", {31'd0, busy}, 32'd0);
    check("seq rst done", {31'd0, done}, 32'd0);
    check("seq rst quot", quot, 32'd0);
    check("seq rst rem",  rem,  32'd0);
    check("seq rst byz",  {31'd0, byz}, 32'd0);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) hits++;
      tick();
    end
    check("seq aborted_no_done", 32'(hits), 32'd0);

    // randomized operations
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        3:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      model(rs, ra, rb, mq, mr, mz);
      run_op($sformatf("rnd%0d s=%0d 0x%08h/0x%08h", i, rs, ra, rb), rs, ra, rb, mq, mr, mz);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/de1_soc_qsys_nios2_qsys_div_cell.md
# de1_soc_qsys_nios2_qsys_div_cell

Sequential 32-bit integer divider cell for the Nios II custom datapath, the inverse companion to the pipelined multiplier cell. Accepts a dividend/divisor pair with a start pulse and returns quotient and remainder after a fixed 34-cycle latency. Uses a radix-2 restoring algorithm on operand magnitudes, with sign fix-up for signed operation. Sits beside the multiplier cell in the A-stage and is stalled on by the pipeline while `A_div_busy` is high.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is verified.
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `A_div_start`  in  1  request; sampled only in IDLE.
- `A_div_signed`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- `A_div_src1`  in  32  dividend; sampled with start.
- `A_div_src2`  in  32  divisor; sampled with start.
- `A_div_busy`  out  1  operation in progress; start ignored.
- `A_div_done`  out  1  single-cycle pulse, results valid.
- `A_div_quotient`  out  32  quotient.
- `A_div_remainder`  out  32  remainder.
- `A_div_by_zero`  out  1  divisor was zero; valid with done, held with results.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - If `A_div_start`=1, latch operand magnitudes (negate negative operands when signed), sign flags, original dividend, and a zero-divisor flag.
  - Load iteration counter = 31, partial remainder = 0, go to CALC.
- CALC, one iteration per cycle:
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude as a 33-bit subtraction. If it does not borrow, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - At counter = 0, go to FIX; otherwise decrement.
- FIX:
  - Signed: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - Write the output registers and pulse done. Go to IDLE.
- Division truncates toward zero. The remainder takes the sign of the dividend. |remainder| < |divisor|.
- Divide by zero, either mode: quotient = 0xFFFFFFFF, remainder = original dividend, `A_div_by_zero`=1.
- Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0, `A_div_by_zero`=0. No trap; this falls out of the 32-bit magnitude path.
- Outputs hold their last values until the next FIX overwrites them.
- `A_div_by_zero` is cleared on each new result.

## Timing
- Start high in cycle 0 (IDLE). `A_div_busy` is high in cycles 1–33.
- CALC runs in cycles 1–32 and FIX in cycle 33.
- `A_div_done`=1 in cycle 34 only, with results valid from cycle 34.
- The cell is back in IDLE in cycle 34. A start in cycle 34 is accepted, so back-to-back ops issue every 34 cycles.
- Start while busy is ignored: no queuing, operands not resampled.
- Operand inputs may change freely after the start cycle.
- Reset, including mid-operation, takes effect at the next edge:
  - state = IDLE;
  - busy = 0, done = 0, by_zero = 0;
  - quotient = 0, remainder = 0.
- No done pulse is produced for an aborted operation.
- Reset wins over a simultaneous start.

## Test plan
- Unsigned 100 / 7, start at cycle 0:
  - busy high cycles 1–33, done only at cycle 34;
  - quotient = 14, remainder = 2, by_zero = 0.
- Signed 0xFFFFFFF9 (−7) / 2:
  - quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF.
- Signed 7 / 0xFFFFFFFE (−2):
  - quotient = 0xFFFFFFFD, remainder = 1.
- Unsigned 5 / 0, then signed 0xFFFFFFFB / 0:
  - first: quotient = 0xFFFFFFFF, remainder = 5, by_zero = 1;
  - second: quotient = 0xFFFFFFFF, remainder = 0xFFFFFFFB, by_zero = 1.
- 0x80000000 / 0xFFFFFFFF:
  - signed: quotient = 0x80000000, remainder = 0;
  - unsigned: quotient = 0, remainder = 0x80000000.
- Control sequencing:
  - start 100/7 at cycle 0;
  - pulse start with 9/3 at cycle 5, which must be ignored (result 14/2 at cycle 34);
  - start 9/3 at cycle 34, giving quotient = 3, remainder = 0 with done at cycle 68;
  - reset at cycle 80 during a third op started at cycle 70: all outputs 0 from cycle 81, no done for that op.
